// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, host command bytes, device acknowledge,
// and the host-to-device frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StBits,
    StAck,
    StWaitIdle,
    StError
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS         = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE_REPORTING = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET            = 8'hFF;
  localparam logic [7:0] PS2_ACK                  = 8'hFA;

  // Bits sent after the start bit, LSB first: data, odd parity, stop.
  function automatic logic [9:0] ps2_tx_frame(input logic [7:0] data_byte);
    return {1'b1, ~^data_byte, data_byte};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// One PS/2 line: two-flop synchronizer, FilterLen-sample debounce, and a one-cycle pulse
// when the filtered level falls. Lines idle high, so everything resets to 1.
module ps2_line_filter #(
  parameter int unsigned FilterLen = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FilterLen > 1) ? $clog2(FilterLen) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            fall_q, fall_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // The level only moves after FilterLen consecutive samples disagree with it.
  always_comb begin
    level_d = level_q;
    fall_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntW'(FilterLen - 1)) begin
        level_d = sync2_q;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_transmitter.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked bits, acknowledge.
// Define PS2_TX_TIMEOUT_EN to add a watchdog that forces an error if a transfer stalls.
module ps2_transmitter
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_FREQUENCY_HZ = 108_000_000,
  parameter int unsigned INHIBIT_US       = 100,
  parameter int unsigned TIMEOUT_US       = 20000,
  parameter int unsigned FILTER_LEN       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  output logic       ps2_clock_oe,
  output logic       ps2_data_oe,
  input  logic       ie,
  input  logic [7:0] data,
  output logic       busy,
  output logic       done_tick,
  output logic       error_tick
);

  // 64-bit products: the default microsecond-times-hertz values overflow 32 bits.
  localparam int unsigned InhibitCycles =
      32'(64'(INHIBIT_US) * 64'(CLK_FREQUENCY_HZ) / 64'd1_000_000);
  localparam int unsigned InhW = (InhibitCycles > 2) ? $clog2(InhibitCycles) : 1;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int unsigned TimeoutCycles =
      32'(64'(TIMEOUT_US) * 64'(CLK_FREQUENCY_HZ) / 64'd1_000_000);
  localparam int unsigned TimeoutW = (TimeoutCycles > 2) ? $clog2(TimeoutCycles) : 1;

  logic [TimeoutW-1:0] wd_q, wd_d;
`endif

  ps2_tx_state_e   state_q, state_d;
  logic [InhW-1:0] inh_cnt_q, inh_cnt_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [9:0]      shift_q, shift_d;
  logic            clock_oe_q, clock_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            busy_q, busy_d;
  logic            done_tick_q, done_tick_d;
  logic            error_tick_q, error_tick_d;

  logic clk_level, clk_fall, data_level, unused_data_fall;

  ps2_line_filter #(
    .FilterLen(FILTER_LEN)
  ) u_clock_filter (
    .clk_i  (clk),
    .rst_i  (reset),
    .line_i (ps2_clock),
    .level_o(clk_level),
    .fall_o (clk_fall)
  );

  ps2_line_filter #(
    .FilterLen(FILTER_LEN)
  ) u_data_filter (
    .clk_i  (clk),
    .rst_i  (reset),
    .line_i (ps2_data),
    .level_o(data_level),
    .fall_o (unused_data_fall)
  );

  always_comb begin
    state_d      = state_q;
    inh_cnt_d    = inh_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    clock_oe_d   = clock_oe_q;
    data_oe_d    = data_oe_q;
    busy_d       = busy_q;
    done_tick_d  = 1'b0;
    error_tick_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        clock_oe_d = 1'b0;
        data_oe_d  = 1'b0;
        if (ie) begin
          state_d    = StInhibit;
          shift_d    = ps2_tx_frame(data);
          inh_cnt_d  = '0;
          clock_oe_d = 1'b1;
          busy_d     = 1'b1;
        end
      end
      StInhibit: begin
        inh_cnt_d = inh_cnt_q + 1'b1;
        // Start bit goes low one cycle before the clock is released.
        if (inh_cnt_q == InhW'(InhibitCycles - 2)) begin
          data_oe_d = 1'b1;
        end
        if (inh_cnt_q == InhW'(InhibitCycles - 1)) begin
          state_d    = StRts;
          clock_oe_d = 1'b0;
          data_oe_d  = 1'b1;
        end
      end
      StRts: begin
        if (clk_fall) begin
          state_d   = StBits;
          bit_idx_d = '0;
        end
      end
      StBits: begin
        if (clk_fall) begin
          data_oe_d = ~shift_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 4'd9) begin
            state_d = StAck;
          end
        end
      end
      StAck: begin
        if (clk_fall) begin
          state_d = data_level ? StError : StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (clk_level && data_level) begin
          state_d     = StIdle;
          done_tick_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      StError: begin
        clock_oe_d   = 1'b0;
        data_oe_d    = 1'b0;
        error_tick_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    wd_d = '0;
    if (state_q != StIdle) begin
      wd_d = wd_q + 1'b1;
      // Expiry wins over anything else this cycle, including a pending done.
      if (state_q != StError && wd_q == TimeoutW'(TimeoutCycles - 1)) begin
        state_d     = StError;
        clock_oe_d  = 1'b0;
        data_oe_d   = 1'b0;
        done_tick_d = 1'b0;
        busy_d      = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      inh_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      clock_oe_q   <= 1'b0;
      data_oe_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_tick_q  <= 1'b0;
      error_tick_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      inh_cnt_q    <= inh_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      clock_oe_q   <= clock_oe_d;
      data_oe_q    <= data_oe_d;
      busy_q       <= busy_d;
      done_tick_q  <= done_tick_d;
      error_tick_q <= error_tick_d;
`ifdef PS2_TX_TIMEOUT_EN
      wd_q         <= wd_d;
`endif
    end
  end

  assign ps2_clock_oe = clock_oe_q;
  assign ps2_data_oe  = data_oe_q;
  assign busy         = busy_q;
  assign done_tick    = done_tick_q;
  assign error_tick   = error_tick_q;

endmodule

// File: tb/tb_ps2_transmitter.sv
// Bench for ps2_transmitter: directed transfers against an open-drain PS/2 device model,
// with a scoreboard queue of expected ticks/frames checked by an independent monitor.
`timescale 1ns/1ps
module tb_ps2_transmitter;
  import ps2_pkg::*;

  localparam int unsigned ClkHz     = 1_000_000;
  localparam int unsigned InhCycles = 100;    // 100 us at 1 MHz
  localparam int unsigned ToCycles  = 20000;  // 20000 us at 1 MHz
  localparam int unsigned Half      = 25;     // device clock half period, in cycles

  localparam int ModeAck     = 0;
  localparam int ModeNoAck   = 1;
  localparam int ModeNoClock = 2;
  localparam int ModeReset   = 3;
  localparam int ModeIePulse = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ie;
  logic [7:0] data;
  logic       ps2_clock, ps2_data, ps2_clock_oe, ps2_data_oe;
  logic       busy, done_tick, error_tick;
  logic       dev_clk_pull, dev_data_pull;

  always #5 clk = ~clk;

  assign ps2_clock = ~(ps2_clock_oe | dev_clk_pull);
  assign ps2_data  = ~(ps2_data_oe | dev_data_pull);

  ps2_transmitter #(
    .CLK_FREQUENCY_HZ(ClkHz),
    .INHIBIT_US      (100),
    .TIMEOUT_US      (20000),
    .FILTER_LEN      (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ps2_clock   (ps2_clock),
    .ps2_data    (ps2_data),
    .ps2_clock_oe(ps2_clock_oe),
    .ps2_data_oe (ps2_data_oe),
    .ie          (ie),
    .data        (data),
    .busy        (busy),
    .done_tick   (done_tick),
    .error_tick  (error_tick)
  );

  typedef struct {
    logic        is_err;
    logic        chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] dev_frame;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  int unsigned accept_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every tick pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && (done_tick || error_tick)) begin
      check("single_tick", 32'(done_tick & error_tick), 32'd0);
      check("busy_low_at_tick", 32'(busy), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_tick", {30'd0, done_tick, error_tick}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("tick_is_error", 32'(error_tick), 32'(e.is_err));
        if (e.chk_frame) check("wire_frame", 32'(dev_frame), 32'(e.frame));
        if (error_tick) check("oe_released_on_error", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
      end
    end
  end

  // Issue one request and play the device side. frame = {stop, parity, data, start}.
  task automatic send(input logic [7:0] b, input logic [10:0] fr, input int mode);
    int          low;
    int          dfirst;
    logic [10:0] f;
    if (mode == ModeAck || mode == ModeIePulse) exp_q.push_back('{1'b0, 1'b1, fr});
    else if (mode == ModeNoAck) exp_q.push_back('{1'b1, 1'b1, fr});
`ifdef PS2_TX_TIMEOUT_EN
    else if (mode == ModeNoClock) exp_q.push_back('{1'b1, 1'b0, 11'd0});
`endif
    @(negedge clk);
    ie = 1'b1;
    data = b;
    accept_cyc = cyc;
    @(negedge clk);
    ie = 1'b0;
    data = 8'h00;
    check("busy_rise", 32'(busy), 32'd1);
    check("inhibit_start", 32'(ps2_clock_oe), 32'd1);
    low = 0;
    dfirst = -1;
    while (ps2_clock_oe && low < int'(InhCycles) + 10) begin
      if (ps2_data_oe && dfirst < 0) dfirst = low;
      low++;
      @(negedge clk);
    end
    check("inhibit_len", 32'(low), 32'(InhCycles));
    check("start_bit_cycle", 32'(dfirst), 32'(InhCycles - 1));
    check("rts_data_low", 32'(ps2_data_oe), 32'd1);
    if (mode == ModeNoClock) return;
    f = '0;
    tick_n(Half);
    for (int i = 0; i < 12; i++) begin
      if (mode == ModeIePulse && i == 3) begin
        ie = 1'b1;
        data = 8'h11;
        @(negedge clk);
        ie = 1'b0;
        data = 8'h00;
        check("busy_while_ignored_ie", 32'(busy), 32'd1);
      end
      dev_clk_pull = 1'b1;
      if (mode == ModeReset && i == 5) begin
        tick_n(15);
        reset = 1'b1;
        #1;
        check("reset_mid_oe", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
        check("reset_mid_busy", 32'(busy), 32'd0);
        tick_n(2);
        dev_clk_pull = 1'b0;
        reset = 1'b0;
        tick_n(2 * Half);
        return;
      end
      tick_n(Half);
      if (i <= 10) f[i] = ps2_data;
      dev_clk_pull = 1'b0;
      if (i == 10) begin
        dev_frame = f;
        if (mode != ModeNoAck) dev_data_pull = 1'b1;
      end
      tick_n(Half);
    end
    dev_data_pull = 1'b0;
    for (int g = 0; g < 200 && exp_q.size() != 0; g++) @(negedge clk);
    check("tick_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick_n(Half);
  endtask

  initial begin
    reset = 1'b1;
    ie = 1'b0;
    data = 8'h00;
    dev_clk_pull = 1'b0;
    dev_data_pull = 1'b0;
    dev_frame = '0;
    tick_n(3);
    check("rst_clock_oe", 32'(ps2_clock_oe), 32'd0);
    check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_error", 32'(error_tick), 32'd0);
    reset = 1'b0;
    tick_n(20);

    // 0xF4: five ones, odd parity bit 0.
    send(PS2_CMD_ENABLE_REPORTING, 11'h5E8, ModeAck);
    // 0xED: six ones, parity 1.
    send(PS2_CMD_SET_LEDS, 11'h7DA, ModeAck);
    // 0x00: parity 1.
    send(8'h00, 11'h600, ModeAck);
    send(PS2_CMD_ENABLE_REPORTING, 11'h5E8, ModeNoAck);
    check("idle_after_error", {30'd0, ps2_clock_oe, ps2_data_oe}, 32'd0);
    send(PS2_CMD_ENABLE_REPORTING, 11'h5E8, ModeIePulse);
    send(PS2_CMD_ENABLE_REPORTING, 11'h5E8, ModeReset);
    check("no_pending_after_reset", 32'(exp_q.size()), 32'd0);
    // 0xFF: eight ones, parity 1.
    send(PS2_CMD_RESET, 11'h7FE, ModeAck);

    send(PS2_CMD_ENABLE_REPORTING, 11'h000, ModeNoClock);
`ifdef PS2_TX_TIMEOUT_EN
    for (int g = 0; g < int'(ToCycles) + 200 && !error_tick; g++) @(negedge clk);
    check("timeout_in_window",
          32'(((cyc - accept_cyc) >= ToCycles) && ((cyc - accept_cyc) <= ToCycles + 5)), 32'd1);
    tick_n(3);
    check("timeout_tick_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
`else
    tick_n(ToCycles + 100);
    check("no_watchdog_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("recover_busy", 32'(busy), 32'd0);
    tick_n(2);
    reset = 1'b0;
`endif
    tick_n(20);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
